// File: rtl/svm_kernel_accumulator_pkg.sv
// Shared definitions for the SVM kernel accumulator: the CORDIC width that sets the
// kernel width, plus sign-extension and saturation helpers used by the saturating
// build (SVM_ACC_SATURATE_EN).
package svm_kernel_accumulator_pkg;

    // Kernel width produced by the upstream CORDIC stage.
    localparam int unsigned SVM_CORDIC_WIDTH = 16;

    // Working width for saturating arithmetic; accumulator widths must stay below it.
    localparam int unsigned WIDE_WIDTH = 64;

    typedef logic signed [WIDE_WIDTH-1:0] wide_t;

    // Sign-extend the low w bits of v to the full working width.
    function automatic wide_t sext_from(input wide_t v, input int unsigned w);
        wide_t r;
        r = v;
        for (int unsigned b = 0; b < WIDE_WIDTH; b++) begin
            if (b >= w) begin
                r[b] = v[w-1];
            end
        end
        return r;
    endfunction

    // True when v does not fit in a w-bit two's-complement value.
    function automatic logic sat_ovf(input wide_t v, input int unsigned w);
        wide_t max_v;
        wide_t min_v;
        max_v = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        min_v = -(wide_t'(1) <<< (w - 1));
        return (v > max_v) || (v < min_v);
    endfunction

endpackage

// File: rtl/svm_kernel_accumulator_if.sv
// Kernel-in / coefficient-ROM / decision-out bundle of the SVM kernel accumulator.
// The decision_saturated flag exists only when SVM_ACC_SATURATE_EN is defined.
interface svm_kernel_accumulator_if
    import svm_kernel_accumulator_pkg::*;
#(
    parameter int unsigned WIDTH      = SVM_CORDIC_WIDTH,
    parameter int unsigned COEF_WIDTH = 16,
    parameter int unsigned ACC_WIDTH  = 40,
    parameter int unsigned IDX_WIDTH  = 6
);
    logic [WIDTH-1:0]      kernel_value;
    logic                  kernel_valid_nxt;
    logic [IDX_WIDTH-1:0]  sv_index;
    logic [COEF_WIDTH-1:0] coef;
    logic [ACC_WIDTH-1:0]  bias;
    logic                  abort;
    logic                  decision_valid;
    logic [ACC_WIDTH-1:0]  decision_value;
    logic                  decision_class;
`ifdef SVM_ACC_SATURATE_EN
    logic                  decision_saturated;
`endif

    // Upstream side: kernel source, coefficient ROM and result consumer.
    modport master (
        output kernel_value, kernel_valid_nxt, coef, bias, abort,
`ifdef SVM_ACC_SATURATE_EN
        input  decision_saturated,
`endif
        input  sv_index, decision_valid, decision_value, decision_class
    );

    // Accumulator side.
    modport slave (
        input  kernel_value, kernel_valid_nxt, coef, bias, abort,
`ifdef SVM_ACC_SATURATE_EN
        output decision_saturated,
`endif
        output sv_index, decision_valid, decision_value, decision_class
    );

endinterface

// File: rtl/svm_kernel_accumulator_mac.sv
// Two-stage multiply-accumulate for the SVM decision function: stage 1 forms
// alpha_i*K_i, stage 2 accumulates and adds the bias on the last term.
// SVM_ACC_SATURATE_EN selects saturating instead of wrapping arithmetic.
module svm_mac_stage
    import svm_kernel_accumulator_pkg::*;
#(
    parameter int unsigned WIDTH      = SVM_CORDIC_WIDTH,
    parameter int unsigned COEF_WIDTH = 16,
    parameter int unsigned ACC_WIDTH  = 40
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_kernel_valid,
    input  logic                  i_abort,
    input  logic                  i_first,
    input  logic                  i_last,
    input  logic [WIDTH-1:0]      i_kernel,
    input  logic [COEF_WIDTH-1:0] i_coef,
    input  logic [ACC_WIDTH-1:0]  i_bias,
    output logic                  o_fire,
    output logic [ACC_WIDTH-1:0]  o_value
`ifdef SVM_ACC_SATURATE_EN
    ,
    output logic                  o_saturated
`endif
);
    localparam int unsigned PROD_WIDTH = WIDTH + COEF_WIDTH + 1;

    logic [PROD_WIDTH-1:0] w_kernel_ext;
    logic [PROD_WIDTH-1:0] w_coef_ext;
    logic [PROD_WIDTH-1:0] w_prod;
    logic                  w_take;
    logic                  w_en;
    logic [ACC_WIDTH-1:0]  w_sum;
    logic [ACC_WIDTH-1:0]  w_dec;

    logic [PROD_WIDTH-1:0] r_prod;
    logic                  r_prod_valid;
    logic                  r_prod_first;
    logic                  r_prod_last;
    logic [ACC_WIDTH-1:0]  r_acc;

    // Kernel is an unsigned fraction, so it gets a zero sign bit before the signed multiply.
    assign w_kernel_ext = {{(COEF_WIDTH + 1){1'b0}}, i_kernel};
    assign w_coef_ext   = {{(WIDTH + 1){i_coef[COEF_WIDTH-1]}}, i_coef};
    assign w_prod       = $signed(w_kernel_ext) * $signed(w_coef_ext);
    assign w_take       = i_kernel_valid && !i_abort;
    // Abort also discards a product already in flight.
    assign w_en         = r_prod_valid && !i_abort;

`ifdef SVM_ACC_SATURATE_EN
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH - 1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH - 1){1'b0}}};

    wide_t w_sum_wide;
    wide_t w_dec_wide;
    logic  w_sum_ovf;
    logic  w_dec_ovf;
    logic  w_sat_so_far;
    logic  r_sat;

    // Saturating accumulate and bias add, computed wide and clipped back to ACC_WIDTH.
    always_comb begin
        w_sum_wide = (r_prod_first ? '0 : sext_from(wide_t'(r_acc), ACC_WIDTH))
                     + sext_from(wide_t'(r_prod), PROD_WIDTH);
        w_sum_ovf  = sat_ovf(w_sum_wide, ACC_WIDTH);
        w_sum      = w_sum_ovf ? (w_sum_wide[WIDE_WIDTH-1] ? ACC_MIN : ACC_MAX)
                               : w_sum_wide[ACC_WIDTH-1:0];
        w_dec_wide = sext_from(wide_t'(w_sum), ACC_WIDTH) + sext_from(wide_t'(i_bias), ACC_WIDTH);
        w_dec_ovf  = sat_ovf(w_dec_wide, ACC_WIDTH);
        w_dec      = w_dec_ovf ? (w_dec_wide[WIDE_WIDTH-1] ? ACC_MIN : ACC_MAX)
                               : w_dec_wide[ACC_WIDTH-1:0];
        w_sat_so_far = (r_prod_first ? 1'b0 : r_sat) | w_sum_ovf;
    end

    // Sticky saturation flag for the classification in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sat <= 1'b0;
        end else if (w_en) begin
            r_sat <= w_sat_so_far;
        end
    end

    assign o_saturated = w_sat_so_far | w_dec_ovf;
`else
    logic [ACC_WIDTH-1:0] w_prod_ext;

    // Wrapping accumulate and bias add.
    always_comb begin
        w_prod_ext = {{(ACC_WIDTH - PROD_WIDTH){r_prod[PROD_WIDTH-1]}}, r_prod};
        w_sum      = (r_prod_first ? '0 : r_acc) + w_prod_ext;
        w_dec      = w_sum + i_bias;
    end
`endif

    // Stage 1: register the product and its position within the vector.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prod       <= '0;
            r_prod_valid <= 1'b0;
            r_prod_first <= 1'b0;
            r_prod_last  <= 1'b0;
        end else begin
            r_prod_valid <= w_take;
            if (w_take) begin
                r_prod       <= w_prod;
                r_prod_first <= i_first;
                r_prod_last  <= i_last;
            end
        end
    end

    // Stage 2: accumulate; the first term of a vector overwrites the old sum.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc <= '0;
        end else if (w_en) begin
            r_acc <= w_sum;
        end
    end

    assign o_fire  = w_en && r_prod_last;
    assign o_value = w_dec;

endmodule

// File: rtl/svm_kernel_accumulator.sv
// SVM kernel accumulator top: support-vector counter, coefficient ROM addressing one
// cycle ahead of the kernel, and the decision output register.
// Optional saturation and decision_saturated output: SVM_ACC_SATURATE_EN.
module svm_kernel_accumulator
    import svm_kernel_accumulator_pkg::*;
#(
    parameter int unsigned WIDTH      = SVM_CORDIC_WIDTH,
    parameter int unsigned COEF_WIDTH = 16,
    parameter int unsigned ACC_WIDTH  = 40,
    parameter int unsigned SV_COUNT   = 64,
    parameter int unsigned IDX_WIDTH  = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    svm_kernel_accumulator_if.slave bus
);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(SV_COUNT - 1);

    logic                 r_kernel_valid;
    logic [IDX_WIDTH-1:0] r_count;
    logic [IDX_WIDTH-1:0] w_count_inc;
    logic                 w_fire;
    logic [ACC_WIDTH-1:0] w_value;
    logic                 r_dec_valid;
    logic [ACC_WIDTH-1:0] r_dec_value;
    logic                 r_dec_class;
`ifdef SVM_ACC_SATURATE_EN
    logic                 w_sat;
    logic                 r_dec_sat;
`endif

    assign w_count_inc  = (r_count == LAST_IDX) ? '0 : r_count + 1'b1;
    // Address the ROM for the next kernel so its coefficient lands with it.
    assign bus.sv_index = r_kernel_valid ? w_count_inc : r_count;

    // Input valid pipeline and support-vector counter; abort restarts the vector.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_kernel_valid <= 1'b0;
            r_count        <= '0;
        end else if (bus.abort) begin
            r_kernel_valid <= 1'b0;
            r_count        <= '0;
        end else begin
            r_kernel_valid <= bus.kernel_valid_nxt;
            if (r_kernel_valid) begin
                r_count <= w_count_inc;
            end
        end
    end

    svm_mac_stage #(
        .WIDTH      (WIDTH),
        .COEF_WIDTH (COEF_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk            (clk),
        .reset          (reset),
        .i_kernel_valid (r_kernel_valid),
        .i_abort        (bus.abort),
        .i_first        (r_count == '0),
        .i_last         (r_count == LAST_IDX),
        .i_kernel       (bus.kernel_value),
        .i_coef         (bus.coef),
        .i_bias         (bus.bias),
        .o_fire         (w_fire),
        .o_value        (w_value)
`ifdef SVM_ACC_SATURATE_EN
        ,
        .o_saturated    (w_sat)
`endif
    );

    // Decision register: pulse valid and capture the result on the last term.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dec_valid <= 1'b0;
            r_dec_value <= '0;
            r_dec_class <= 1'b0;
`ifdef SVM_ACC_SATURATE_EN
            r_dec_sat   <= 1'b0;
`endif
        end else begin
            r_dec_valid <= w_fire;
            if (w_fire) begin
                r_dec_value <= w_value;
                r_dec_class <= ~w_value[ACC_WIDTH-1];
`ifdef SVM_ACC_SATURATE_EN
                r_dec_sat   <= w_sat;
`endif
            end
        end
    end

    assign bus.decision_valid = r_dec_valid;
    assign bus.decision_value = r_dec_value;
    assign bus.decision_class = r_dec_class;
`ifdef SVM_ACC_SATURATE_EN
    assign bus.decision_saturated = r_dec_sat;
`endif

endmodule
